video_out_stage: RTL and testbench
==================================

VIDEO_OUT_STAGE -- requirements
Module: video_out_stage

Interface
REQ-001 SHALL have parameter C_bits_r, default 2: red input width, 1..8.
REQ-002 SHALL have parameter C_bits_g, default 3: green input width, 1..8.
REQ-003 SHALL have parameter C_bits_b, default 3: blue input width, 1..8.
REQ-004 SHALL have parameter C_depth, default 3: output width per colour, 1..8.
REQ-005 SHALL have parameter C_pipe, default 1: pipeline register stages, 1..4.
REQ-006 SHALL have parameters C_hs_pol and C_vs_pol, default 1'b1: active level of the incoming hsync and vsync.
REQ-007 SHALL have the following ports, clock and reset first:
- clk_pixel  input  1  pixel clock, the only clock.
- reset  input  1  synchronous, active-high.
- in_red / in_green / in_blue  input  C_bits_r / C_bits_g / C_bits_b  pixel colour.
- in_hsync, in_vsync  input  1  sync, with the polarities set by the parameters.
- in_blank  input  1  1 = blanking.
- out_red, out_green, out_blue  output  C_depth  expanded colour.
- out_hsync, out_vsync, out_blank  output  1  sync and blank, normalised active-high.
- h_total, h_active, v_total, v_active  output  12  measured timing (macro-dependent).
- timing_stable  output  1  measured timing has been constant for 2 frames.

Function
REQ-008 SHALL delay colour, sync and blank by exactly C_pipe clk_pixel cycles, keeping them mutually aligned.
REQ-009 SHALL normalise sync polarity: out_hsync = in_hsync XNOR C_hs_pol, and likewise for vsync, before entering the pipeline.
REQ-010 SHALL expand a colour channel whose input is narrower than C_depth by cyclic MSB-first bit replication. Example: 2-bit "ab" to 3 bits gives "aba".
REQ-011 SHALL reduce a colour channel whose input is wider than C_depth by keeping the C_depth MSBs.
REQ-012 SHALL pass a colour channel whose input equals C_depth unchanged.
REQ-013 SHALL force out_red, out_green and out_blue to 0 on any cycle where out_blank = 1.
REQ-014 SHALL detect a line start as a rising edge of normalised hsync and a frame start as a rising edge of normalised vsync, using a 1-cycle edge register.
REQ-015 SHALL use a 12-bit pixel counter that increments every cycle and counts unblanked cycles since the last line start; at each line start it latches h_total = count, latches h_active = unblanked count, then restarts both.
REQ-016 SHALL use a 12-bit line counter that counts line starts and lines containing at least one unblanked pixel; at each frame start it latches v_total and v_active, then restarts.
REQ-017 SHALL saturate all counters at 4095 with no wrap-around; a saturated value is latched as 4095.
REQ-018 SHALL, when a line start and a frame start occur on the same cycle, perform the line latch first and then the frame latch, with the line counter reset to 0.
REQ-019 SHALL assert timing_stable one cycle after a frame latch whose four values equal those of the previous frame latch, and clear it one cycle after any latch that differs.
REQ-020 SHALL keep h_total, h_active, v_total and v_active at 0 until their first latch.

Reset
REQ-021 SHALL, while reset = 1 at a clk_pixel edge, clear every pipeline stage, so outputs read colour 0, out_hsync = 0, out_vsync = 0 and out_blank = 1.
REQ-022 SHALL, while reset = 1, clear all counters, the edge registers, the measured values and timing_stable.
REQ-023 SHALL, when reset is asserted mid-line, discard the partial measurement; the first valid latch is the second line start after reset is released.

Configuration
REQ-024 SHALL compile the measurement logic of REQ-014 to REQ-020 only when macro VIDEO_OUT_MEASURE_EN is defined.
REQ-025 SHALL, without VIDEO_OUT_MEASURE_EN, tie h_total, h_active, v_total, v_active and timing_stable to constant 0 while leaving the ports present.

Structure
REQ-026 SHALL place the 12-bit timing width constant and the replication helper function in shared package video_pkg.
REQ-027 SHALL implement the measurement logic as sub-module video_timing_meter, instantiated only under VIDEO_OUT_MEASURE_EN.

Verification
REQ-028 SHALL cover expansion and latency: C_pipe=1, C_bits_r=2, C_depth=3, in_red=2'b10 unblanked -> out_red=3'b101 exactly 1 cycle later; C_pipe=3 -> 3 cycles later.
REQ-029 SHALL cover blank and polarity: C_hs_pol=0, in_hsync=0, in_blank=1, colour all-ones -> out_hsync=1 and out colour 0.
REQ-030 SHALL cover measurement: 800x525 frame, 640x480 active, macro on -> h_total=800, h_active=640, v_total=525, v_active=480; timing_stable=1 after the second identical frame.
REQ-031 SHALL cover saturation and glitch: hsync held inactive for 5000 cycles -> h_total=4095; a subsequent frame with v_total=526 -> timing_stable drops to 0.
REQ-032 SHALL cover reset mid-line: reset asserted at pixel 300 for 2 cycles -> outputs equal reset values (REQ-021); h_total stays 0 until the second line start after release.
REQ-033 SHALL cover the macro-off build: any stimulus -> all measured outputs and timing_stable read 0.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_pkg
// Purpose : Shared timing width, saturating increment and colour replication
//           index helper for the video output stage.
// Revision: 1.0  initial release
// ============================================================================
package video_pkg;

  localparam int unsigned TIMING_W = 12;

  typedef logic [TIMING_W-1:0] timing_t;

  localparam timing_t TIMING_MAX = '1;
  localparam timing_t TIMING_ONE = timing_t'(1);

  // Source bit feeding output bit position out_idx (counted from the MSB).
  // Cyclic MSB-first replication; for in_w >= out_w this selects the MSBs.
  function automatic int rep_src_bit(input int out_idx, input int in_w);
    return in_w - 1 - (out_idx % in_w);
  endfunction

  function automatic timing_t sat_inc(input timing_t v);
    return (v == TIMING_MAX) ? v : v + TIMING_ONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_out_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : video_out_stage_if
// Purpose : Measured video timing bundle (totals, active counts, stability).
// Revision: 1.0  initial release
// ============================================================================
interface video_out_stage_if;
  import video_pkg::*;

  timing_t h_total;
  timing_t h_active;
  timing_t v_total;
  timing_t v_active;
  logic    timing_stable;

  modport master (output h_total, h_active, v_total, v_active, timing_stable);
  modport slave  (input  h_total, h_active, v_total, v_active, timing_stable);

endinterface
`default_nettype wire

// File: rtl/video_timing_meter.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_meter
// Purpose : Measures line/frame totals and active counts from normalised sync.
// Revision: 1.0  initial release
// ============================================================================
module video_timing_meter
  import video_pkg::*;
(
  input  logic              clk_pixel,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  video_out_stage_if.master meas
);

  logic    hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic    line_armed_q, line_armed_d, frame_armed_q, frame_armed_d;
  timing_t pix_cnt_q, pix_cnt_d, act_cnt_q, act_cnt_d;
  timing_t line_cnt_q, line_cnt_d, line_act_q, line_act_d;
  timing_t h_total_q, h_total_d, h_active_q, h_active_d;
  timing_t v_total_q, v_total_d, v_active_q, v_active_d;
  logic [4*TIMING_W-1:0] snap_q, snap_d;
  logic    snap_valid_q, snap_valid_d;
  logic    cmp_pend_q, cmp_pend_d;
  logic    stable_q, stable_d;
  logic    line_start, frame_start;

  assign line_start  = hsync & ~hs_prev_q;
  assign frame_start = vsync & ~vs_prev_q;

  always_comb begin
    hs_prev_d     = hsync;
    vs_prev_d     = vsync;
    line_armed_d  = line_armed_q;
    frame_armed_d = frame_armed_q;
    pix_cnt_d     = pix_cnt_q;
    act_cnt_d     = act_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_act_d    = line_act_q;
    h_total_d     = h_total_q;
    h_active_d    = h_active_q;
    v_total_d     = v_total_q;
    v_active_d    = v_active_q;
    snap_d        = snap_q;
    snap_valid_d  = snap_valid_q;
    cmp_pend_d    = 1'b0;
    stable_d      = stable_q;

    // The first line start after reset only arms; its line is partial.
    if (line_start) begin
      line_armed_d = 1'b1;
      pix_cnt_d    = TIMING_ONE;
      act_cnt_d    = blank ? '0 : TIMING_ONE;
      if (line_armed_q) begin
        h_total_d  = pix_cnt_q;
        h_active_d = act_cnt_q;
        line_cnt_d = sat_inc(line_cnt_q);
        if (act_cnt_q != '0) begin
          line_act_d = sat_inc(line_act_q);
        end
      end
    end else begin
      pix_cnt_d = sat_inc(pix_cnt_q);
      if (!blank) begin
        act_cnt_d = sat_inc(act_cnt_q);
      end
    end

    // Frame latch sees the line counts already advanced by a coincident line start.
    if (frame_start) begin
      frame_armed_d = 1'b1;
      if (frame_armed_q) begin
        v_total_d  = line_cnt_d;
        v_active_d = line_act_d;
        cmp_pend_d = 1'b1;
      end
      line_cnt_d = '0;
      line_act_d = '0;
    end

    if (cmp_pend_q) begin
      stable_d     = snap_valid_q &&
                     (snap_q == {h_total_q, h_active_q, v_total_q, v_active_q});
      snap_d       = {h_total_q, h_active_q, v_total_q, v_active_q};
      snap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      line_armed_q  <= 1'b0;
      frame_armed_q <= 1'b0;
      pix_cnt_q     <= '0;
      act_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_act_q    <= '0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      snap_q        <= '0;
      snap_valid_q  <= 1'b0;
      cmp_pend_q    <= 1'b0;
      stable_q      <= 1'b0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      line_armed_q  <= line_armed_d;
      frame_armed_q <= frame_armed_d;
      pix_cnt_q     <= pix_cnt_d;
      act_cnt_q     <= act_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_act_q    <= line_act_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      snap_q        <= snap_d;
      snap_valid_q  <= snap_valid_d;
      cmp_pend_q    <= cmp_pend_d;
      stable_q      <= stable_d;
    end
  end

  assign meas.h_total       = h_total_q;
  assign meas.h_active      = h_active_q;
  assign meas.v_total       = v_total_q;
  assign meas.v_active      = v_active_q;
  assign meas.timing_stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/video_out_stage.sv
`default_nettype none
// ============================================================================
// Module  : video_out_stage
// Purpose : Colour depth conversion, sync normalisation, blanking and an
//           aligned output pipeline; timing measurement when
//           VIDEO_OUT_MEASURE_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module video_out_stage
  import video_pkg::*;
#(
  parameter int   C_bits_r = 2,
  parameter int   C_bits_g = 3,
  parameter int   C_bits_b = 3,
  parameter int   C_depth  = 3,
  parameter int   C_pipe   = 1,
  parameter logic C_hs_pol = 1'b1,
  parameter logic C_vs_pol = 1'b1
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [C_bits_r-1:0] in_red,
  input  logic [C_bits_g-1:0] in_green,
  input  logic [C_bits_b-1:0] in_blue,
  input  logic                in_hsync,
  input  logic                in_vsync,
  input  logic                in_blank,
  output logic [C_depth-1:0]  out_red,
  output logic [C_depth-1:0]  out_green,
  output logic [C_depth-1:0]  out_blue,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                out_blank,
  output timing_t             h_total,
  output timing_t             h_active,
  output timing_t             v_total,
  output timing_t             v_active,
  output logic                timing_stable
);

  localparam int PW = 3 * C_depth + 3;
  // Stage layout {red, green, blue, hsync, vsync, blank}; reset is blank only.
  localparam logic [PW-1:0] PIPE_RST = {{(PW-1){1'b0}}, 1'b1};

  logic [C_depth-1:0]   red_exp, green_exp, blue_exp;
  logic [3*C_depth-1:0] colour_in;
  logic                 hs_n, vs_n;
  logic                 unused_in;
  logic [PW-1:0]        pipe_d [C_pipe];
  logic [PW-1:0]        pipe_q [C_pipe];

  for (genvar k = 0; k < C_depth; k++) begin : g_expand
    assign red_exp[C_depth-1-k]   = in_red[rep_src_bit(k, C_bits_r)];
    assign green_exp[C_depth-1-k] = in_green[rep_src_bit(k, C_bits_g)];
    assign blue_exp[C_depth-1-k]  = in_blue[rep_src_bit(k, C_bits_b)];
  end

  // Dropped LSBs of a narrowed channel are intentionally ignored.
  assign unused_in = ^{in_red, in_green, in_blue};

  assign hs_n      = ~(in_hsync ^ C_hs_pol);
  assign vs_n      = ~(in_vsync ^ C_vs_pol);
  assign colour_in = in_blank ? '0 : {red_exp, green_exp, blue_exp};

  always_comb begin
    pipe_d[0] = {colour_in, hs_n, vs_n, in_blank};
    for (int i = 1; i < C_pipe; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_pixel) begin
    for (int i = 0; i < C_pipe; i++) begin
      if (reset) begin
        pipe_q[i] <= PIPE_RST;
      end else begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign {out_red, out_green, out_blue, out_hsync, out_vsync, out_blank} = pipe_q[C_pipe-1];

`ifdef VIDEO_OUT_MEASURE_EN
  video_out_stage_if u_meas_if ();

  video_timing_meter u_meter (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .hsync     (hs_n),
    .vsync     (vs_n),
    .blank     (in_blank),
    .meas      (u_meas_if)
  );

  assign h_total       = u_meas_if.h_total;
  assign h_active      = u_meas_if.h_active;
  assign v_total       = u_meas_if.v_total;
  assign v_active      = u_meas_if.v_active;
  assign timing_stable = u_meas_if.timing_stable;
`else
  assign h_total       = '0;
  assign h_active      = '0;
  assign v_total       = '0;
  assign v_active      = '0;
  assign timing_stable = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_out_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_out_stage
// Purpose : Directed self-checking bench: expansion, latency, polarity,
//           blanking, timing measurement, saturation and mid-line reset.
// Revision: 1.0  initial release
// ============================================================================
module tb_video_out_stage;
  import video_pkg::*;

`ifdef VIDEO_OUT_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] in_red;
  logic [2:0] in_green, in_blue;
  logic [4:0] in_green5;
  logic       in_hsync, in_vsync, in_blank;

  logic [2:0] a_red, a_green, a_blue, b_red, b_green, b_blue;
  logic       a_hs, a_vs, a_blank, b_hs, b_vs, b_blank;
  timing_t    b_ht, b_ha, b_vt, b_va;
  logic       b_ts;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  video_out_stage_if u_tif ();

  video_out_stage #(
    .C_bits_r(2), .C_bits_g(3), .C_bits_b(3), .C_depth(3), .C_pipe(1),
    .C_hs_pol(1'b1), .C_vs_pol(1'b1)
  ) u_dut_a (
    .clk_pixel(clk), .reset(reset),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_blank(in_blank),
    .out_red(a_red), .out_green(a_green), .out_blue(a_blue),
    .out_hsync(a_hs), .out_vsync(a_vs), .out_blank(a_blank),
    .h_total(u_tif.h_total), .h_active(u_tif.h_active),
    .v_total(u_tif.v_total), .v_active(u_tif.v_active),
    .timing_stable(u_tif.timing_stable)
  );

  video_out_stage #(
    .C_bits_r(2), .C_bits_g(5), .C_bits_b(3), .C_depth(3), .C_pipe(3),
    .C_hs_pol(1'b0), .C_vs_pol(1'b0)
  ) u_dut_b (
    .clk_pixel(clk), .reset(reset),
    .in_red(in_red), .in_green(in_green5), .in_blue(in_blue),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_blank(in_blank),
    .out_red(b_red), .out_green(b_green), .out_blue(b_blue),
    .out_hsync(b_hs), .out_vsync(b_vs), .out_blank(b_blank),
    .h_total(b_ht), .h_active(b_ha), .v_total(b_vt), .v_active(b_va),
    .timing_stable(b_ts)
  );

  function automatic int m(input int v);
    return MEAS ? v : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic hs, input logic vs, input logic blk, input logic [1:0] r,
                        input logic [2:0] g, input logic [4:0] g5, input logic [2:0] b);
    in_hsync = hs; in_vsync = vs; in_blank = blk;
    in_red = r; in_green = g; in_green5 = g5; in_blue = b;
  endtask

  // Cycles [from,to) of a line: hsync on cycles 0-1, nact unblanked from cycle 2.
  task automatic line_part(input int nact, input logic vs, input int from, input int to);
    for (int c = from; c < to; c++) begin
      set_px(c < 2, vs, !(c >= 2 && c < 2 + nact), 2'($urandom), 3'($urandom),
             5'($urandom), 3'($urandom));
      cyc();
    end
  endtask

  // Short 8-cycle lines keep vertical counts real while one long 800/640 line
  // ends every frame, so the frame latch captures the horizontal figures.
  task automatic frame_head();
    line_part(4, 1'b1, 0, 3);
  endtask

  task automatic frame_body(input int nlines);
    line_part(4, 1'b1, 3, 8);
    for (int l = 1; l < nlines - 1; l++) begin
      line_part((l < 479) ? 4 : 0, l < 2, 0, 8);
    end
    line_part(640, 1'b0, 0, 800);
  endtask

  initial begin
    reset = 1'b1;
    set_px(1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 5'b11111, 3'b111);
    cyc(); cyc();
    chk("rst_a_red",   a_red,   0);
    chk("rst_a_blank", a_blank, 1);
    chk("rst_a_hs",    a_hs,    0);
    chk("rst_b_hs",    b_hs,    0);
    chk("rst_b_vs",    b_vs,    0);
    chk("rst_b_blank", b_blank, 1);
    chk("rst_htotal",  u_tif.h_total, 0);
    chk("rst_stable",  u_tif.timing_stable, 0);
    reset = 1'b0;

    // Expansion, narrowing and latency
    set_px(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'b00000, 3'b000);
    cyc(); cyc(); cyc();
    set_px(1'b0, 1'b0, 1'b0, 2'b10, 3'b110, 5'b10110, 3'b011);
    cyc();
    chk("p1_red_k0",   a_red,   3'b101);
    chk("p1_green_k0", a_green, 3'b110);
    chk("p1_blue_k0",  a_blue,  3'b011);
    chk("p1_blank_k0", a_blank, 0);
    chk("p3_red_k0",   b_red,   0);
    in_red = 2'b01; cyc();
    chk("p1_red_k1",   a_red,   3'b010);
    chk("p3_red_k1",   b_red,   0);
    in_red = 2'b11; cyc();
    chk("p1_red_k2",   a_red,   3'b111);
    chk("p3_red_k2",   b_red,   3'b101);
    chk("p3_green_k2", b_green, 3'b101);
    chk("p3_blue_k2",  b_blue,  3'b011);
    in_red = 2'b00; cyc();
    chk("p3_red_k3",   b_red,   3'b010);
    cyc();
    chk("p3_red_k4",   b_red,   3'b111);

    // Polarity and blank forcing
    set_px(1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 5'b11111, 3'b111);
    cyc(); cyc(); cyc();
    chk("pol_b_hs",    b_hs,    1);
    chk("pol_b_vs",    b_vs,    1);
    chk("blk_b_red",   b_red,   0);
    chk("blk_b_green", b_green, 0);
    chk("blk_b_blue",  b_blue,  0);
    chk("blk_b_blank", b_blank, 1);
    chk("pol_a_hs",    a_hs,    0);
    chk("blk_a_red",   a_red,   0);
    in_hsync = 1'b1; cyc();
    chk("pol_a_hs_hi", a_hs,    1);
    chk("pol_b_hs_lo", b_hs,    1);

    // Timing measurement over full frames
    set_px(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 5'b00000, 3'b000);
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0; cyc();
    frame_head();
    chk("f1_htotal", u_tif.h_total, 0);
    chk("f1_vtotal", u_tif.v_total, 0);
    frame_body(525);
    frame_head();
    chk("f2_htotal",  u_tif.h_total,  m(800));
    chk("f2_hactive", u_tif.h_active, m(640));
    chk("f2_vtotal",  u_tif.v_total,  m(525));
    chk("f2_vactive", u_tif.v_active, m(480));
    chk("f2_stable",  u_tif.timing_stable, 0);
    frame_body(525);
    frame_head();
    chk("f3_vtotal",  u_tif.v_total, m(525));
    chk("f3_stable",  u_tif.timing_stable, m(1));
    frame_body(526);
    frame_head();
    chk("f4_vtotal",  u_tif.v_total,  m(526));
    chk("f4_vactive", u_tif.v_active, m(480));
    chk("f4_stable",  u_tif.timing_stable, 0);

    // Saturation: hsync inactive for 5000 cycles
    line_part(4, 1'b1, 3, 8);
    line_part(10, 1'b0, 0, 5002);
    line_part(640, 1'b0, 0, 3);
    chk("sat_htotal",  u_tif.h_total,  m(4095));
    chk("sat_hactive", u_tif.h_active, m(10));

    // Reset asserted at pixel 300 for two cycles
    line_part(640, 1'b0, 3, 300);
    reset = 1'b1;
    line_part(640, 1'b0, 300, 301);
    chk("mrst_a_red",   a_red,   0);
    chk("mrst_a_blank", a_blank, 1);
    chk("mrst_b_blank", b_blank, 1);
    chk("mrst_b_hs",    b_hs,    0);
    chk("mrst_htotal",  u_tif.h_total, 0);
    line_part(640, 1'b0, 301, 302);
    chk("mrst_b_red",   b_red,   0);
    chk("mrst_a_vs",    a_vs,    0);
    reset = 1'b0;
    line_part(640, 1'b0, 302, 800);
    line_part(640, 1'b0, 0, 3);
    chk("mrst_ls1_htotal", u_tif.h_total, 0);
    line_part(640, 1'b0, 3, 800);
    line_part(640, 1'b0, 0, 3);
    chk("mrst_ls2_htotal",  u_tif.h_total,  m(800));
    chk("mrst_ls2_hactive", u_tif.h_active, m(640));
    chk("mrst_stable",      u_tif.timing_stable, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
